// File: rtl/mac.sv
// Registered multiply-accumulate cell: io_out <= io_a * io_b + io_c, one-cycle latency.
// Define MAC_SIGNED_EN for two's-complement operands; default build is unsigned.
module mac #(
    parameter int A_WIDTH   = 8,
    parameter int B_WIDTH   = 8,
    parameter int C_WIDTH   = 16,
    parameter int OUT_WIDTH = 17
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [A_WIDTH-1:0]   io_a,
    input  logic [B_WIDTH-1:0]   io_b,
    input  logic [C_WIDTH-1:0]   io_c,
    output logic [OUT_WIDTH-1:0] io_out
);

    localparam int P_WIDTH = A_WIDTH + B_WIDTH;

    logic [P_WIDTH-1:0]   a_ext_s;
    logic [P_WIDTH-1:0]   b_ext_s;
    logic [P_WIDTH-1:0]   prod_s;
    logic [OUT_WIDTH-1:0] prod_ext_s;
    logic [OUT_WIDTH-1:0] c_ext_s;
    logic [OUT_WIDTH-1:0] sum_d;
    logic [OUT_WIDTH-1:0] out_q;

    // Extend operands to product width, multiply, then extend and add at result width.
    always_comb begin
        a_ext_s    = {P_WIDTH{1'b0}};
        b_ext_s    = {P_WIDTH{1'b0}};
        prod_s     = {P_WIDTH{1'b0}};
        prod_ext_s = {OUT_WIDTH{1'b0}};
        c_ext_s    = {OUT_WIDTH{1'b0}};
        sum_d      = {OUT_WIDTH{1'b0}};
`ifdef MAC_SIGNED_EN
        // Multiplying sign-extended operands at P_WIDTH yields the exact signed product.
        a_ext_s    = {{B_WIDTH{io_a[A_WIDTH-1]}}, io_a};
        b_ext_s    = {{A_WIDTH{io_b[B_WIDTH-1]}}, io_b};
        prod_s     = a_ext_s * b_ext_s;
        prod_ext_s = {{(OUT_WIDTH-P_WIDTH){prod_s[P_WIDTH-1]}}, prod_s};
        c_ext_s    = {{(OUT_WIDTH-C_WIDTH){io_c[C_WIDTH-1]}}, io_c};
`else
        a_ext_s    = {{B_WIDTH{1'b0}}, io_a};
        b_ext_s    = {{A_WIDTH{1'b0}}, io_b};
        prod_s     = a_ext_s * b_ext_s;
        prod_ext_s = {{(OUT_WIDTH-P_WIDTH){1'b0}}, prod_s};
        c_ext_s    = {{(OUT_WIDTH-C_WIDTH){1'b0}}, io_c};
`endif
        sum_d      = prod_ext_s + c_ext_s;
    end

    // Output register: cleared by synchronous reset, otherwise captures every cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_q <= {OUT_WIDTH{1'b0}};
        end else begin
            out_q <= sum_d;
        end
    end

    assign io_out = out_q;

endmodule

// File: tb/tb_mac.sv
// Scoreboard bench for mac: stimulus pushes expected results, a monitor pops and compares each cycle.
// Honors MAC_SIGNED_EN so the same bench covers both builds.
module tb_mac;

    localparam int AW = 8;
    localparam int BW = 8;
    localparam int CW = 16;
    localparam int OW = 17;

    logic          clock;
    logic          reset;
    logic [AW-1:0] io_a;
    logic [BW-1:0] io_b;
    logic [CW-1:0] io_c;
    logic [OW-1:0] io_out;

    logic [OW-1:0] exp_q[$];
    string         name_q[$];
    int            checks;
    int            errors;

    mac #(
        .A_WIDTH  (AW),
        .B_WIDTH  (BW),
        .C_WIDTH  (CW),
        .OUT_WIDTH(OW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .io_a  (io_a),
        .io_b  (io_b),
        .io_c  (io_c),
        .io_out(io_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model built from integer arithmetic.
    function automatic logic [OW-1:0] model(input logic [AW-1:0] a, input logic [BW-1:0] b,
                                            input logic [CW-1:0] c);
        longint r;
        logic [OW-1:0] res;
`ifdef MAC_SIGNED_EN
        r = longint'($signed(a)) * longint'($signed(b)) + longint'($signed(c));
`else
        r = longint'(a) * longint'(b) + longint'(c);
`endif
        res = r[OW-1:0];
        return res;
    endfunction

    task automatic drive(input logic [AW-1:0] a, input logic [BW-1:0] b, input logic [CW-1:0] c,
                         input logic r, input logic [OW-1:0] exp, input string nm);
        @(negedge clock);
        io_a  = a;
        io_b  = b;
        io_c  = c;
        reset = r;
        exp_q.push_back(exp);
        name_q.push_back(nm);
    endtask

    // Monitor: one result per cycle, sampled 1 time unit after the rising edge.
    always @(posedge clock) begin
        logic [OW-1:0] e;
        string         nm;
        #1;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            checks = checks + 1;
            if (io_out !== e) begin
                errors = errors + 1;
                $display("FAIL %s: io_out=0x%0h expected=0x%0h", nm, io_out, e);
            end
        end
    end

    initial begin
        logic [AW-1:0] ra;
        logic [BW-1:0] rb;
        logic [CW-1:0] rc;
        int            wait_cycles;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        io_a   = 8'h00;
        io_b   = 8'h00;
        io_c   = 16'h0000;

        drive(8'hFF, 8'hFF, 16'hFFFF, 1'b1, 17'h00000, "reset_edge1");
        drive(8'hFF, 8'hFF, 16'hFFFF, 1'b1, 17'h00000, "reset_edge2");
`ifdef MAC_SIGNED_EN
        drive(8'hFF, 8'hFF, 16'hFFFF, 1'b0, 17'h00000, "reset_release");
`else
        drive(8'hFF, 8'hFF, 16'hFFFF, 1'b0, 17'h1FE00, "reset_release");
`endif
        drive(8'd3, 8'd5, 16'd7, 1'b0, 17'd22, "basic_3x5p7");
        drive(8'd0, 8'd0, 16'd0, 1'b0, 17'd0, "basic_zero");
`ifdef MAC_SIGNED_EN
        drive(8'h80, 8'h7F, 16'h8000, 1'b0, 17'h14080, "signed_min");
        drive(8'hFF, 8'hFF, 16'h0000, 1'b0, 17'h00001, "signed_m1xm1");
        drive(8'h7F, 8'h7F, 16'h7FFF, 1'b0, 17'h0BF00, "signed_max");
`else
        drive(8'd255, 8'd255, 16'd65535, 1'b0, 17'd130560, "max_unsigned");
        drive(8'd255, 8'd0, 16'd65535, 1'b0, 17'd65535, "c_only");
        drive(8'd128, 8'd2, 16'd0, 1'b0, 17'd256, "product_only");
`endif
        for (int i = 1; i <= 16; i++) begin
            drive(AW'(i), 8'd10, 16'd100, 1'b0, OW'(100 + 10 * i), "weight_stationary");
        end

        for (int i = 0; i < 50; i++) begin
            ra = AW'($urandom);
            rb = BW'($urandom);
            rc = CW'($urandom);
            drive(ra, rb, rc, 1'b0, model(ra, rb, rc), "random_pre");
        end
        ra = AW'($urandom);
        rb = BW'($urandom);
        rc = CW'($urandom);
        drive(ra, rb, rc, 1'b1, 17'h00000, "midstream_reset");
        for (int i = 0; i < 20; i++) begin
            ra = AW'($urandom);
            rb = BW'($urandom);
            rc = CW'($urandom);
            drive(ra, rb, rc, 1'b0, model(ra, rb, rc), "random_post");
        end

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clock);
            wait_cycles = wait_cycles + 1;
        end
        #2;
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
